mem_port_master: RTL and testbench

MEM_PORT_MASTER -- requirements
Module: mem_port_master

---
 rtl/mem_port_master.sv | 106 ++++++++++
 tb/tb_mem_port_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_master.sv
// Single-port memory master: one request at a time, walked through
// SETUP / STROBE / HOLD, with the response held until the consumer takes it.
module mem_port_master #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] wait_cnt;
    logic       wr_q;

    // Only the low 4K words are mapped; anything above is an error response.
    function automatic logic addr_out_of_range(input logic [31:0] a);
        return |a[31:12];
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // mem_addr / mem_din double as the request latches, so they only move at accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            wr_q      <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_din   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        rsp_rdata <= 32'd0;
                        if (addr_out_of_range(req_addr)) begin
                            rsp_err <= 1'b1;
                            state   <= RESP;
                        end else begin
                            rsp_err  <= 1'b0;
                            mem_addr <= req_addr;
                            mem_din  <= req_wdata;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    wait_cnt <= CNT_INIT;
                    mem_wen  <= wr_q;
                    mem_ren  <= ~wr_q;
                    state    <= STROBE;
                end
                STROBE: begin
                    if (wait_cnt == 4'd0) begin
                        mem_wen <= 1'b0;
                        mem_ren <= 1'b0;
                        if (!wr_q) begin
                            rsp_rdata <= mem_dout;
                        end
                        state <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Directed and random bench for mem_port_master: one instance at WAIT_CYCLES=1
// backed by a small memory model, one at WAIT_CYCLES=4 for timing and reset.
module tb_mem_port_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int nchk = 0;
    int nerr = 0;

    logic        a_reset, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
    logic        a_rsp_err, a_mem_ren, a_mem_wen;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata, a_mem_addr, a_mem_din, a_mem_dout;

    logic        b_reset, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
    logic        b_rsp_err, b_mem_ren, b_mem_wen;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_mem_addr, b_mem_din, b_mem_dout;

    mem_port_master #(.WAIT_CYCLES(1)) dut_a (
        .clock(clock), .reset(a_reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .mem_dout(a_mem_dout)
    );

    mem_port_master #(.WAIT_CYCLES(4)) dut_b (
        .clock(clock), .reset(b_reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
        .mem_dout(b_mem_dout)
    );

    // Reference memory for dut_a: 64 words, combinational read while loading.
    logic [31:0] mem [0:63];
    always @(posedge clock) if (a_mem_wen) mem[a_mem_addr[5:0]] <= a_mem_din;
    assign a_mem_dout = (a_mem_ren && !a_mem_wen) ? mem[a_mem_addr[5:0]] : 32'h0;
    assign b_mem_dout = b_mem_ren ? 32'hA5A5_0000 : 32'h0;

    // Continuous watch on dut_a: strobe exclusivity and address stability.
    int          viol = 0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_strobe = 1'b0;
    always @(negedge clock) begin
        if (a_mem_wen && a_mem_ren) viol++;
        if (prev_strobe && a_mem_addr !== prev_addr) viol++;
        prev_strobe = a_mem_wen | a_mem_ren;
        prev_addr   = a_mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on dut_a; k counts edges after the accept edge E0.
    task automatic run_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int bp, input bit rel,
                         output int vk, output int vc, output int wc, output int rc,
                         output logic [31:0] rd, output logic er, output int bad);
        int k;
        bit done;
        vk = -1; vc = 0; wc = 0; rc = 0; rd = 32'h0; er = 1'b0; bad = 0; done = 0;
        @(negedge clock);
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = a; a_req_wdata = d;
        a_rsp_ready = (bp == 0);
        if (rel) a_reset = 1'b1;
        if (!a_req_ready) bad++;
        @(posedge clock);
        #1;
        a_req_valid = 1'b0; a_req_addr = ~a; a_req_wdata = ~d; a_req_write = ~w;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clock);
            if (a_mem_wen) begin
                wc++;
                if (a_mem_addr !== a || a_mem_din !== d) bad++;
            end
            if (a_mem_ren) begin
                rc++;
                if (a_mem_addr !== a) bad++;
            end
            if (a_rsp_valid) begin
                vc++;
                if (vk < 0) begin
                    vk = k; rd = a_rsp_rdata; er = a_rsp_err;
                end else if (a_rsp_rdata !== rd || a_rsp_err !== er) begin
                    bad++;
                end
                if (a_req_ready) bad++;
                if (k - vk >= bp) begin
                    a_rsp_ready = 1'b1;
                    done = 1;
                end
            end
            @(posedge clock);
            k++;
        end
        if (!done) bad++;
    endtask

    task automatic run_b(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int vk, output int wc, output int rc, output logic [31:0] rd,
                         output int bad);
        int k;
        bit done;
        vk = -1; wc = 0; rc = 0; rd = 32'h0; bad = 0; done = 0;
        @(negedge clock);
        b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        @(posedge clock);
        #1 b_req_valid = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clock);
            if (b_mem_wen) begin
                wc++;
                if (b_mem_addr !== a || b_mem_din !== d) bad++;
            end
            if (b_mem_ren) rc++;
            if (b_rsp_valid) begin
                vk = k; rd = b_rsp_rdata;
                if (b_rsp_err) bad++;
                done = 1;
            end
            @(posedge clock);
            k++;
        end
        if (!done) bad++;
    endtask

    int          vk, vc, wc, rc, bad, rmis, seen;
    logic [31:0] rd, addr, data, exp_rd;
    logic        er, w;
    logic [31:0] shadow [0:63];

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_rsp_ready = 1'b1;
        #1 a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(a_rsp_err),   32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata,      32'd0);
        chk("rst_strobes",   {30'd0, a_mem_ren, a_mem_wen}, 32'd0);
        chk("rst_mem_addr",  a_mem_addr, 32'd0);
        chk("rst_mem_din",   a_mem_din,  32'd0);
        b_reset = 1'b1;

        // Store, accepted on the first edge after reset release
        run_a(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b1, vk, vc, wc, rc, rd, er, bad);
        chk("st_wen_cycles", 32'(wc), 32'd1);
        chk("st_ren_cycles", 32'(rc), 32'd0);
        chk("st_vld_edge",   32'(vk), 32'd3);
        chk("st_vld_cycles", 32'(vc), 32'd1);
        chk("st_rdata",      rd, 32'd0);
        chk("st_err",        32'(er), 32'd0);
        chk("st_bus",        32'(bad), 32'd0);
        @(negedge clock);
        chk("st_idle", {30'd0, a_req_ready, a_rsp_valid}, 32'd2);

        // Load of the same word
        run_a(1'b0, 32'h10, 32'h0, 0, 1'b0, vk, vc, wc, rc, rd, er, bad);
        chk("ld_rdata",      rd, 32'hDEADBEEF);
        chk("ld_vld_edge",   32'(vk), 32'd3);
        chk("ld_ren_cycles", 32'(rc), 32'd1);
        chk("ld_wen_cycles", 32'(wc), 32'd0);
        chk("ld_err",        32'(er), 32'd0);

        // Out-of-range address
        run_a(1'b1, 32'h0000_1000, 32'h5555_5555, 0, 1'b0, vk, vc, wc, rc, rd, er, bad);
        chk("err_strobes",   32'(wc + rc), 32'd0);
        chk("err_vld_edge",  32'(vk), 32'd0);
        chk("err_vld_cycles",32'(vc), 32'd1);
        chk("err_flag",      32'(er), 32'd1);
        chk("err_rdata",     rd, 32'd0);

        // Back-pressure: rsp_ready low for 5 edges while in RESP
        run_a(1'b0, 32'h10, 32'h0, 5, 1'b0, vk, vc, wc, rc, rd, er, bad);
        chk("bp_rdata",      rd, 32'hDEADBEEF);
        chk("bp_vld_cycles", 32'(vc), 32'd6);
        chk("bp_hold",       32'(bad), 32'd0);
        @(negedge clock);
        chk("bp_idle", 32'(a_req_ready), 32'd1);

        // WAIT_CYCLES=4 timing
        run_b(1'b1, 32'h20, 32'h1234_5678, vk, wc, rc, rd, bad);
        chk("w4_st_wen_cycles", 32'(wc), 32'd4);
        chk("w4_st_vld_edge",   32'(vk), 32'd6);
        chk("w4_st_bus",        32'(bad), 32'd0);
        run_b(1'b0, 32'h20, 32'h0, vk, wc, rc, rd, bad);
        chk("w4_ld_ren_cycles", 32'(rc), 32'd4);
        chk("w4_ld_rdata",      rd, 32'hA5A5_0000);

        // Reset during the second strobe cycle of a WAIT_CYCLES=4 store
        @(negedge clock);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h24; b_req_wdata = 32'hCAFE_F00D;
        @(posedge clock);
        #1 b_req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("rs_wen_before", 32'(b_mem_wen), 32'd1);
        #1 b_reset = 1'b0;
        #1;
        chk("rs_wen_dropped", 32'(b_mem_wen), 32'd0);
        chk("rs_ready_in_rst", 32'(b_req_ready), 32'd1);
        repeat (2) @(negedge clock);
        b_reset = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (b_rsp_valid || b_mem_wen || b_mem_ren) seen++;
        end
        chk("rs_no_response", 32'(seen), 32'd0);
        chk("rs_ready_after", 32'(b_req_ready), 32'd1);

        // Random traffic on dut_a, after filling the model with known words
        for (int i = 0; i < 64; i++) begin
            data = $urandom;
            run_a(1'b1, 32'(i), data, 0, 1'b0, vk, vc, wc, rc, rd, er, bad);
            shadow[i] = data;
        end
        rmis = 0;
        for (int n = 0; n < 1000; n++) begin
            w = 1'($urandom_range(0, 1));
            data = $urandom;
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
            else addr = 32'($urandom_range(0, 63));
            run_a(w, addr, data, 0, 1'b0, vk, vc, wc, rc, rd, er, bad);
            if (addr >= 32'h1000) begin
                if (er !== 1'b1 || rd !== 32'h0 || vk != 0 || wc != 0 || rc != 0) rmis++;
            end else begin
                exp_rd = w ? 32'h0 : shadow[addr[5:0]];
                if (er !== 1'b0 || rd !== exp_rd || vk != 3) rmis++;
                if (wc != (w ? 1 : 0) || rc != (w ? 0 : 1)) rmis++;
                if (w) shadow[addr[5:0]] = data;
            end
            if (bad != 0 || vc != 1) rmis++;
        end
        chk("rand_txn_errors", 32'(rmis), 32'd0);
        chk("rand_strobe_addr_viol", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
